// File: rtl/ctr3_phase_monitor_pkg.sv
// ---------------------------------------------------------------------------
// ctr3_pkg
// Types and constants that the modulo-3 phase monitor and its lock FSM share.
//   PH0/PH1/PH2/PH_ILL        : 2-bit phase codes from the upstream counter
//   lock_state_t              : lock FSM state encoding
//   ERR_NONE/ERR_CODE/ERR_TRANS : sticky error cause codes
//   phase_onehot()            : legal phase -> one-hot strobe, PH_ILL -> 000
// ---------------------------------------------------------------------------
package ctr3_pkg;

    localparam logic [1:0] PH0    = 2'd0;
    localparam logic [1:0] PH1    = 2'd1;
    localparam logic [1:0] PH2    = 2'd2;
    localparam logic [1:0] PH_ILL = 2'd3;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SYNCING  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_CODE  = 2'b01;
    localparam logic [1:0] ERR_TRANS = 2'b10;

    function automatic logic [2:0] phase_onehot(input logic [1:0] ph);
        logic [2:0] oh;
        oh = 3'b000;
        if (ph != PH_ILL) begin
            oh[ph] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/ctr3_phase_monitor_if.sv
// ---------------------------------------------------------------------------
// ctr3_phase_monitor_if
// Bundles the phase input, error clear and all monitor outputs.
//   master : drives Phase/ErrClr, observes the monitor outputs
//   slave  : the monitor itself
// Signals:
//   Phase[1:0]  phase code from the counter      ErrClr     sticky error clear
//   PhaseOH[2:0] one-hot of last legal phase     Wrap       2->0 pulse
//   Restart     legal x->0 (not 2->0) pulse      PeriodCnt  wrap count
//   CntOvf      PeriodCnt roll-over pulse        Locked     lock indication
//   Err         sticky error flag                ErrCode    sticky first cause
// ---------------------------------------------------------------------------
interface ctr3_phase_monitor_if #(
    parameter int CNT_W = 8
);
    logic [1:0]       Phase;
    logic             ErrClr;
    logic [2:0]       PhaseOH;
    logic             Wrap;
    logic             Restart;
    logic [CNT_W-1:0] PeriodCnt;
    logic             CntOvf;
    logic             Locked;
    logic             Err;
    logic [1:0]       ErrCode;

    modport master (
        output Phase, ErrClr,
        input  PhaseOH, Wrap, Restart, PeriodCnt, CntOvf, Locked, Err, ErrCode
    );

    modport slave (
        input  Phase, ErrClr,
        output PhaseOH, Wrap, Restart, PeriodCnt, CntOvf, Locked, Err, ErrCode
    );
endinterface

// File: rtl/ctr3_phase_monitor_lock_fsm.sv
// ---------------------------------------------------------------------------
// ctr3_lock_fsm
// Lock tracker for the phase monitor. Moves UNLOCKED -> SYNCING on a legal 0,
// SYNCING -> LOCKED after LOCK_PERIODS clean wraps, and back to UNLOCKED on
// any error. A restart (upstream reset) drops LOCKED back to SYNCING.
// Ports:
//   Clk, Reset   clock, asynchronous active-high reset
//   wrap         legal 2->0 seen this sample
//   restart      legal 0->0 / 1->0 seen this sample
//   error        illegal code or illegal transition this sample
//   legal_zero   current sample is code 0
//   state        registered lock state
// ---------------------------------------------------------------------------
module ctr3_lock_fsm
    import ctr3_pkg::*;
#(
    parameter int LOCK_PERIODS = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        wrap,
    input  logic        restart,
    input  logic        error,
    input  logic        legal_zero,
    output lock_state_t state
);

    localparam int GW_W = $clog2(LOCK_PERIODS + 1);

    logic [GW_W-1:0] good_wraps;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= UNLOCKED;
            good_wraps <= '0;
        end else begin
            case (state)
                UNLOCKED: begin
                    // A wrap landing here only starts syncing; it is not counted.
                    if (legal_zero && !error) begin
                        state      <= SYNCING;
                        good_wraps <= '0;
                    end
                end
                SYNCING: begin
                    if (error) begin
                        state <= UNLOCKED;
                    end else if (restart) begin
                        good_wraps <= '0;
                    end else if (wrap) begin
                        if (int'(good_wraps) + 1 >= LOCK_PERIODS) begin
                            state      <= LOCKED;
                            good_wraps <= '0;
                        end else begin
                            good_wraps <= good_wraps + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (error) begin
                        state <= UNLOCKED;
                    end else if (restart) begin
                        state      <= SYNCING;
                        good_wraps <= '0;
                    end
                end
                default: begin
                    state      <= UNLOCKED;
                    good_wraps <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ctr3_phase_monitor.sv
// ---------------------------------------------------------------------------
// ctr3_phase_monitor
// Watches the 2-bit modulo-3 counter phase. Each rising edge the phase is
// classified against the previous legal phase; the result drives a one-hot
// strobe, wrap/restart pulses, a period counter, a sticky error register and
// the lock FSM. All outputs are registered (one cycle after the sample).
// Ports:
//   Clk    clock
//   Reset  asynchronous active-high reset
//   bus    ctr3_phase_monitor_if.slave (Phase/ErrClr in, status out)
// ---------------------------------------------------------------------------
module ctr3_phase_monitor
    import ctr3_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int LOCK_PERIODS = 2
) (
    input logic                   Clk,
    input logic                   Reset,
    ctr3_phase_monitor_if.slave   bus
);

    // Sample history
    logic [1:0]       prev_phase;
    logic             prev_valid;

    // Classified events for the current sample
    logic             ill_code;
    logic             ill_trans;
    logic             wrap_ev;
    logic             restart_ev;
    logic             legal_zero;
    logic             error_ev;
    logic [1:0]       err_cause;

    // Output registers
    logic [2:0]       phase_oh;
    logic             wrap_q;
    logic             restart_q;
    logic [CNT_W-1:0] period_cnt;
    logic             cnt_ovf;
    logic             err_q;
    logic [1:0]       err_code;
    lock_state_t      lock_state;

    // NOTE: every signal assigned in always_comb gets a default up front;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        ill_code   = (bus.Phase == PH_ILL);
        legal_zero = (bus.Phase == PH0);
        wrap_ev    = 1'b0;
        restart_ev = 1'b0;
        ill_trans  = 1'b0;
        // With no valid history the first legal code is simply accepted.
        if (prev_valid && !ill_code) begin
            case ({prev_phase, bus.Phase})
                {PH0, PH1}, {PH1, PH2}: ;
                {PH2, PH0}:             wrap_ev    = 1'b1;
                {PH0, PH0}, {PH1, PH0}: restart_ev = 1'b1;
                default:                ill_trans  = 1'b1;
            endcase
        end
        error_ev  = ill_code | ill_trans;
        err_cause = ill_code ? ERR_CODE : ERR_TRANS;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prev_phase <= PH0;
            prev_valid <= 1'b0;
            phase_oh   <= 3'b000;
            wrap_q     <= 1'b0;
            restart_q  <= 1'b0;
            period_cnt <= '0;
            cnt_ovf    <= 1'b0;
            err_q      <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            // An illegal code breaks the history so the next legal code is
            // accepted unchecked.
            prev_valid <= !ill_code;
            if (!ill_code) begin
                prev_phase <= bus.Phase;
            end
            phase_oh  <= phase_onehot(bus.Phase);
            wrap_q    <= wrap_ev;
            restart_q <= restart_ev;

            if (wrap_ev) begin
                period_cnt <= period_cnt + 1'b1;
                cnt_ovf    <= &period_cnt;
            end else begin
                cnt_ovf <= 1'b0;
            end

            // A new error beats ErrClr; otherwise the first cause is held.
            if (error_ev) begin
                err_q <= 1'b1;
                if (err_code == ERR_NONE || bus.ErrClr) begin
                    err_code <= err_cause;
                end
            end else if (bus.ErrClr) begin
                err_q    <= 1'b0;
                err_code <= ERR_NONE;
            end
        end
    end

    ctr3_lock_fsm #(
        .LOCK_PERIODS (LOCK_PERIODS)
    ) u_lock_fsm (
        .Clk        (Clk),
        .Reset      (Reset),
        .wrap       (wrap_ev),
        .restart    (restart_ev),
        .error      (error_ev),
        .legal_zero (legal_zero),
        .state      (lock_state)
    );

    assign bus.PhaseOH   = phase_oh;
    assign bus.Wrap      = wrap_q;
    assign bus.Restart   = restart_q;
    assign bus.PeriodCnt = period_cnt;
    assign bus.CntOvf    = cnt_ovf;
    assign bus.Locked    = (lock_state == LOCKED);
    assign bus.Err       = err_q;
    assign bus.ErrCode   = err_code;

endmodule

// File: tb/tb_ctr3_phase_monitor.sv
// ---------------------------------------------------------------------------
// tb_ctr3_phase_monitor
// Directed bench for ctr3_phase_monitor. Two instances share the stimulus:
// u_dut8 (CNT_W=8) is checked against a vector table covering locking,
// errors, restarts and ErrClr priority; u_dut2 (CNT_W=2) is used for the
// period counter roll-over sequence. Async reset is checked between edges.
// ---------------------------------------------------------------------------
module tb_ctr3_phase_monitor;

    logic       Clk;
    logic       Reset;
    logic [1:0] phase;
    logic       err_clr;

    int tests_run;
    int tests_failed;

    ctr3_phase_monitor_if #(.CNT_W(8)) if8 ();
    ctr3_phase_monitor_if #(.CNT_W(2)) if2 ();

    assign if8.Phase  = phase;
    assign if8.ErrClr = err_clr;
    assign if2.Phase  = phase;
    assign if2.ErrClr = err_clr;

    ctr3_phase_monitor #(.CNT_W(8), .LOCK_PERIODS(2)) u_dut8 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (if8)
    );

    ctr3_phase_monitor #(.CNT_W(2), .LOCK_PERIODS(2)) u_dut2 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (if2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0] ph;
        logic       clr;
        logic [2:0] oh;
        logic       wrap;
        logic       rst_p;
        logic       lk;
        logic       err;
        logic [1:0] code;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] ph, input logic clr, input logic [2:0] oh,
                       input logic wrap, input logic rst_p, input logic lk,
                       input logic err, input logic [1:0] code, input logic [7:0] cnt);
        vec_t v;
        v.ph = ph; v.clr = clr; v.oh = oh; v.wrap = wrap; v.rst_p = rst_p;
        v.lk = lk; v.err = err; v.code = code; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs away from the edge, then sample 1 time unit after it.
    task automatic step(input logic [1:0] ph, input logic clr);
        phase   = ph;
        err_clr = clr;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic check_all_zero8(input string tag);
        check({tag, " PhaseOH"},   32'(if8.PhaseOH),   32'd0);
        check({tag, " Wrap"},      32'(if8.Wrap),      32'd0);
        check({tag, " Restart"},   32'(if8.Restart),   32'd0);
        check({tag, " PeriodCnt"}, 32'(if8.PeriodCnt), 32'd0);
        check({tag, " CntOvf"},    32'(if8.CntOvf),    32'd0);
        check({tag, " Locked"},    32'(if8.Locked),    32'd0);
        check({tag, " Err"},       32'(if8.Err),       32'd0);
        check({tag, " ErrCode"},   32'(if8.ErrCode),   32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        phase        = 2'd0;
        err_clr      = 1'b0;

        //   ph clr  oh     wr rs lk er code  cnt
        // Clean start: lock after the second wrap
        add(0, 0, 3'b001, 0, 0, 0, 0, 2'b00, 0);
        add(1, 0, 3'b010, 0, 0, 0, 0, 2'b00, 0);
        add(2, 0, 3'b100, 0, 0, 0, 0, 2'b00, 0);
        add(0, 0, 3'b001, 1, 0, 0, 0, 2'b00, 1);
        add(1, 0, 3'b010, 0, 0, 0, 0, 2'b00, 1);
        add(2, 0, 3'b100, 0, 0, 0, 0, 2'b00, 1);
        add(0, 0, 3'b001, 1, 0, 1, 0, 2'b00, 2);
        // 0->2 while locked, then resume and re-lock with Err held
        add(2, 0, 3'b100, 0, 0, 0, 1, 2'b10, 2);
        add(0, 0, 3'b001, 1, 0, 0, 1, 2'b10, 3);
        add(1, 0, 3'b010, 0, 0, 0, 1, 2'b10, 3);
        add(2, 0, 3'b100, 0, 0, 0, 1, 2'b10, 3);
        add(0, 0, 3'b001, 1, 0, 0, 1, 2'b10, 4);
        add(1, 0, 3'b010, 0, 0, 0, 1, 2'b10, 4);
        add(2, 0, 3'b100, 0, 0, 0, 1, 2'b10, 4);
        add(0, 0, 3'b001, 1, 0, 1, 1, 2'b10, 5);
        // Clear, illegal code, next legal 1 accepted without transition error
        add(1, 1, 3'b010, 0, 0, 1, 0, 2'b00, 5);
        add(3, 0, 3'b000, 0, 0, 0, 1, 2'b01, 5);
        add(1, 1, 3'b010, 0, 0, 0, 0, 2'b00, 5);
        add(2, 0, 3'b100, 0, 0, 0, 0, 2'b00, 5);
        add(0, 0, 3'b001, 1, 0, 0, 0, 2'b00, 6);
        add(1, 0, 3'b010, 0, 0, 0, 0, 2'b00, 6);
        add(2, 0, 3'b100, 0, 0, 0, 0, 2'b00, 6);
        add(0, 0, 3'b001, 1, 0, 0, 0, 2'b00, 7);
        add(1, 0, 3'b010, 0, 0, 0, 0, 2'b00, 7);
        add(2, 0, 3'b100, 0, 0, 0, 0, 2'b00, 7);
        add(0, 0, 3'b001, 1, 0, 1, 0, 2'b00, 8);
        // Locked, 1->0 restart, then 0 held
        add(1, 0, 3'b010, 0, 0, 1, 0, 2'b00, 8);
        add(0, 0, 3'b001, 0, 1, 0, 0, 2'b00, 8);
        add(0, 0, 3'b001, 0, 1, 0, 0, 2'b00, 8);
        add(0, 0, 3'b001, 0, 1, 0, 0, 2'b00, 8);
        add(0, 0, 3'b001, 0, 1, 0, 0, 2'b00, 8);
        // ErrClr same cycle as 2->1; sticky cause; new cause beats ErrClr
        add(1, 0, 3'b010, 0, 0, 0, 0, 2'b00, 8);
        add(2, 0, 3'b100, 0, 0, 0, 0, 2'b00, 8);
        add(1, 1, 3'b010, 0, 0, 0, 1, 2'b10, 8);
        add(1, 0, 3'b010, 0, 0, 0, 1, 2'b10, 8);
        add(3, 0, 3'b000, 0, 0, 0, 1, 2'b10, 8);
        add(0, 1, 3'b001, 0, 0, 0, 0, 2'b00, 8);
        add(2, 0, 3'b100, 0, 0, 0, 1, 2'b10, 8);
        add(3, 1, 3'b000, 0, 0, 0, 1, 2'b01, 8);
        add(0, 1, 3'b001, 0, 0, 0, 0, 2'b00, 8);

        // Reset state, both during and just after reset
        Reset = 1'b1;
        #2;
        check_all_zero8("in_reset");
        do_reset();
        check_all_zero8("after_reset");

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ph, vecs[i].clr);
            check($sformatf("v%0d PhaseOH", i),   32'(if8.PhaseOH),   32'(vecs[i].oh));
            check($sformatf("v%0d Wrap", i),      32'(if8.Wrap),      32'(vecs[i].wrap));
            check($sformatf("v%0d Restart", i),   32'(if8.Restart),   32'(vecs[i].rst_p));
            check($sformatf("v%0d Locked", i),    32'(if8.Locked),    32'(vecs[i].lk));
            check($sformatf("v%0d Err", i),       32'(if8.Err),       32'(vecs[i].err));
            check($sformatf("v%0d ErrCode", i),   32'(if8.ErrCode),   32'(vecs[i].code));
            check($sformatf("v%0d PeriodCnt", i), 32'(if8.PeriodCnt), 32'(vecs[i].cnt));
            check($sformatf("v%0d CntOvf", i),    32'(if8.CntOvf),    32'd0);
        end

        // Async reset between edges with Err and PeriodCnt non-zero
        step(2, 0);
        check("pre_async Err",       32'(if8.Err),       32'd1);
        check("pre_async PeriodCnt", 32'(if8.PeriodCnt), 32'd8);
        #2;
        Reset = 1'b1;
        #1;
        check_all_zero8("async_reset");
        #1;
        Reset = 1'b0;
        // First legal sample after reset is accepted unchecked
        step(1, 0);
        check("post_reset PhaseOH", 32'(if8.PhaseOH), 32'b010);
        check("post_reset Err",     32'(if8.Err),     32'd0);

        // Period counter roll-over on the CNT_W=2 instance
        do_reset();
        step(0, 0);
        for (int k = 1; k <= 5; k++) begin
            step(1, 0);
            step(2, 0);
            step(0, 0);
            check($sformatf("ovf w%0d PeriodCnt", k), 32'(if2.PeriodCnt), 32'(k % 4));
            check($sformatf("ovf w%0d Wrap", k),      32'(if2.Wrap),      32'd1);
            check($sformatf("ovf w%0d CntOvf", k),    32'(if2.CntOvf),    (k == 4) ? 32'd1 : 32'd0);
        end
        step(1, 0);
        check("ovf after CntOvf", 32'(if2.CntOvf), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
